vga_sprite_engine: RTL and testbench
====================================

# vga_sprite_engine

Parametrised N-sprite compositor for the 640x480 VGA path, successor to the two-sprite fixed-axis renderer. During vertical blank it bursts a position table for `N_SPRITES` sprites out of the shared single-port RAM into a shadow buffer and commits it atomically. During active video it reuses the same port to fetch one sprite pixel per pixel slot and drives VGA colour. It sits between `vga_control` (timing) and the RAM port B of `cpu_top`.

## Interface
- `ADDR_WIDTH`, 16: RAM address width.
- `N_SPRITES`, 4: sprite count, 1..16; index 0 has highest priority.
- `POS_BASE`, 16'h8000: position table base; 2 words per sprite.
- `SPR_BASE`, 0: pixel data base of sprite 0.
- `SPR_STRIDE`, 1024: words between consecutive sprites' pixel data.
- `SPRITE_WIDTH` / `SPRITE_HEIGHT`, 32 / 32: source size in pixels; powers of 2.
- `SCALE_LOG2`, 1: on-screen scale factor is 2^SCALE_LOG2.
- `V_ACTIVE`, 480: first vblank line.
- `BG_COLOR`, 24'h88CC88: background RGB.
- `sys_clk` in 1: single clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `pix_en` in 1: one-cycle pixel strobe (every 2nd `sys_clk`); all state advances only when high.
- `bright` in 1: active-video flag from `vga_control`.
- `hcount`, `vcount` in 10: current pixel coordinates.
- `ram_addr` out ADDR_WIDTH: RAM read address, registered.
- `ram_we` out 1: tied 0.
- `ram_q` in 16: RAM data, valid one `sys_clk` after address (always valid by the next `pix_en`).
- `busy` out 1: position load in progress.
- `frame_loaded` out 1: one-`pix_en`-cycle pulse on table commit.
- `vga_r`, `vga_g`, `vga_b` out 8: colour.

## Operation
- Position word 2i: bit15 = enable, [9:0] = x. Word 2i+1: [9:0] = y. All other bits are ignored.
- Pixel word: bit15 = opaque, [14:10] R, [9:5] G, [4:0] B. Expand each 5-bit channel to 8 bits as {c, c[4:2]}.
- Loader FSM states: IDLE, ISSUE, CAPTURE, COMMIT.
  - `vblank_start` = `pix_en` && hcount==0 && vcount==V_ACTIVE. IDLE→ISSUE on `vblank_start`.
  - The loader is pipelined. Step k drives `ram_addr` = POS_BASE+k. Step k+1 captures `ram_q` into shadow word k.
  - After word 2N-1 is captured: COMMIT. COMMIT copies shadow→live, pulses `frame_loaded`, then returns to IDLE. The load totals 2N+2 `pix_en` cycles.
  - `busy` is 1 in every state except IDLE.
  - `vblank_start` during a load restarts the load at word 0, and the shadow is not committed.
- Hit test, sprite i: dx = hcount − x_i and dy = vcount − y_i, both 11-bit, negative treated as miss. A hit requires enable_i, dx < W<<S and dy < H<<S.
- Fetch address = SPR_BASE + i*SPR_STRIDE + (dy>>S)*W + (dx>>S), truncated to ADDR_WIDTH.
- Winner is the lowest-index hitting sprite. Transparency does not fall through to lower-priority sprites.
- Outside active video, while `busy`, or with no hit: `ram_addr` = 0 and sel = NONE.

## Timing
- Stage 0 (`pix_en`, pixel h): register `ram_addr`, `sel_q` (winner index or NONE) and `bright_q` (bright && !busy).
- Stage 1 (next `pix_en`): colour is combinational from `sel_q`, `bright_q` and `ram_q`. Pixel h is displayed one pixel slot late.
- Colour rules:
  - `bright_q`=0 → black.
  - sel NONE, or opaque=0 → BG_COLOR.
  - Otherwise → decoded pixel.
- Reset values:
  - `ram_addr` 0, `busy` 0, `frame_loaded` 0.
  - `sel_q` NONE, `bright_q` 0, so colour outputs are 0.
  - Live and shadow tables are 0, so all sprites are disabled.
  - FSM is IDLE.
- Reset mid-load aborts the load with no commit. Live table returns to 0.
- Live table changes only in COMMIT, which happens inside vblank. A frame never mixes old and new positions.

## Structure
- Package `vga_sprite_pkg`:
  - Loader state enum.
  - SEL_NONE encoding (sel width is clog2(N_SPRITES)+1).
  - Pixel-decode function: 16-bit word → opaque flag and 24-bit RGB.
- Sub-module `sprite_hit_calc`: instantiated N times. It is combinational and computes hit and fetch address from coordinates, position and sprite index.
- Top level contains the loader FSM, shadow and live tables, priority encoder, stage registers and colour mux.

## Test plan
- Reset then first vblank with N=4 and RAM[0x8000..0x8007] = {0x8064,0x0032, 0,0, 0,0, 0,0} → `ram_addr` walks 0x8000..0x8007. `busy` is high for 10 `pix_en` cycles, then `frame_loaded` pulses once.
- After that load, at h=100, v=50 → `ram_addr` = 0x0000. At h=102, v=52 → 0x0021. At h=164 → miss, `ram_addr` = 0. With RAM pixel 0xFFFF, the colour is FFFFFF one slot later.
- Sprites 0 and 2 both enabled at x=200, y=100 → sprite 0 address used. Sprite 0 pixel 0x0000 (transparent) → BG 88CC88, not sprite 2's colour.
- Enable bit 0 with valid x/y → never hit, and colour is BG across the region.
- `reset` asserted at load step 3 → no `frame_loaded`, all outputs 0. The next vblank completes a normal load.
- Table changes while a frame is displayed → rendering uses the old positions until the COMMIT in the next vblank.

Source files
------------

// File: rtl/vga_sprite_pkg.sv
// rtl/vga_sprite_pkg.sv - shared types and helpers for the sprite compositor
//
// Contents:
//   ld_state_t    position-table loader states
//   sprite_pos_t  one sprite's position entry (enable, x, y)
//   pixel_t       decoded pixel (opaque flag + 24-bit RGB)
//   sel_width     width of the winner-select code for n sprites
//   sel_none      "no sprite" code: the value just past the largest index
//   decode_pixel  16-bit RAM pixel word -> pixel_t
package vga_sprite_pkg;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_ISSUE,
    LD_CAPTURE,
    LD_COMMIT
  } ld_state_t;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
  } sprite_pos_t;

  typedef struct packed {
    logic        opaque;
    logic [23:0] rgb;
  } pixel_t;

  function automatic int sel_width(int n);
    return $clog2(n) + 1;
  endfunction

  // The top bit of the select code is set only for "no sprite".
  function automatic int sel_none(int n);
    return 1 << $clog2(n);
  endfunction

  // 5-bit channels are widened by repeating their top bits so that
  // 0x1F maps to 0xFF and 0x00 to 0x00.
  function automatic pixel_t decode_pixel(logic [15:0] w);
    pixel_t p;
    p.opaque = w[15];
    p.rgb    = {w[14:10], w[14:12], w[9:5], w[9:7], w[4:0], w[4:2]};
    return p;
  endfunction

endpackage

// File: rtl/sprite_hit_calc.sv
// rtl/sprite_hit_calc.sv - per-sprite hit test and pixel fetch address
//
// Combinational. Ports:
//   hcount, vcount  in  current pixel coordinates
//   pos             in  sprite position entry (enable, x, y)
//   sprite_idx      in  sprite number, selects its pixel data block
//   hit             out pixel lies inside the enabled, scaled sprite
//   fetch_addr      out RAM address of the source pixel (valid when hit)
module sprite_hit_calc
  import vga_sprite_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 16,
  parameter int unsigned SPR_BASE      = 0,
  parameter int unsigned SPR_STRIDE    = 1024,
  parameter int          SPRITE_WIDTH  = 32,
  parameter int          SPRITE_HEIGHT = 32,
  parameter int          SCALE_LOG2    = 1
) (
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  input  sprite_pos_t           pos,
  input  logic [3:0]            sprite_idx,
  output logic                  hit,
  output logic [ADDR_WIDTH-1:0] fetch_addr
);

  localparam int          W_LOG2 = $clog2(SPRITE_WIDTH);
  localparam logic [10:0] W_SPAN = 11'(SPRITE_WIDTH << SCALE_LOG2);
  localparam logic [10:0] H_SPAN = 11'(SPRITE_HEIGHT << SCALE_LOG2);

  logic [10:0] dx;
  logic [10:0] dy;

  // 11-bit differences: bit 10 set means the pixel is left of / above the sprite.
  assign dx = {1'b0, hcount} - {1'b0, pos.x};
  assign dy = {1'b0, vcount} - {1'b0, pos.y};

  assign hit = pos.en && !dx[10] && !dy[10] && (dx < W_SPAN) && (dy < H_SPAN);

  assign fetch_addr = ADDR_WIDTH'(SPR_BASE
                                  + 32'(sprite_idx) * SPR_STRIDE
                                  + (32'(dy >> SCALE_LOG2) << W_LOG2)
                                  + 32'(dx >> SCALE_LOG2));

endmodule

// File: rtl/vga_sprite_engine.sv
// rtl/vga_sprite_engine.sv - N-sprite compositor sharing one RAM read port
//
// Ports:
//   sys_clk, reset          clock, synchronous active-high reset
//   pix_en                  pixel strobe; all state advances only when high
//   bright, hcount, vcount  video timing from the VGA controller
//   ram_addr, ram_we, ram_q RAM read port (ram_we held low)
//   busy                    position table load in progress
//   frame_loaded            one-pixel-slot pulse when a new table goes live
//   vga_r, vga_g, vga_b     colour, one pixel slot behind hcount
module vga_sprite_engine
  import vga_sprite_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 16,
  parameter int          N_SPRITES     = 4,
  parameter int unsigned POS_BASE      = 32'h8000,
  parameter int unsigned SPR_BASE      = 0,
  parameter int unsigned SPR_STRIDE    = 1024,
  parameter int          SPRITE_WIDTH  = 32,
  parameter int          SPRITE_HEIGHT = 32,
  parameter int          SCALE_LOG2    = 1,
  parameter int          V_ACTIVE      = 480,
  parameter logic [23:0] BG_COLOR      = 24'h88CC88
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  pix_en,
  input  logic                  bright,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [15:0]           ram_q,
  output logic                  busy,
  output logic                  frame_loaded,
  output logic [7:0]            vga_r,
  output logic [7:0]            vga_g,
  output logic [7:0]            vga_b
);

  localparam int                IDX_W    = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam int                CNT_W    = IDX_W + 2;
  localparam int                SEL_W    = sel_width(N_SPRITES);
  localparam logic [SEL_W-1:0]  SEL_NONE = SEL_W'(sel_none(N_SPRITES));
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(2 * N_SPRITES);

  ld_state_t             state;
  logic [CNT_W-1:0]      ld_cnt;     // next word to request; word ld_cnt-1 arrives now
  logic [IDX_W:0]        cap_word;
  logic                  vblank_start;

  sprite_pos_t           shadow [N_SPRITES];
  sprite_pos_t           live   [N_SPRITES];

  logic [N_SPRITES-1:0]  hit;
  logic [ADDR_WIDTH-1:0] fetch  [N_SPRITES];

  logic [SEL_W-1:0]      sel_d;
  logic [SEL_W-1:0]      sel_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  bright_q;

  pixel_t                px;
  logic [23:0]           rgb;

  assign ram_we       = 1'b0;
  assign busy         = (state != LD_IDLE);
  assign vblank_start = pix_en && (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));
  assign cap_word     = (IDX_W + 1)'(ld_cnt - 1'b1);

  for (genvar i = 0; i < N_SPRITES; i++) begin : g_hit
    sprite_hit_calc #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .SPR_BASE     (SPR_BASE),
      .SPR_STRIDE   (SPR_STRIDE),
      .SPRITE_WIDTH (SPRITE_WIDTH),
      .SPRITE_HEIGHT(SPRITE_HEIGHT),
      .SCALE_LOG2   (SCALE_LOG2)
    ) u_hit (
      .hcount    (hcount),
      .vcount    (vcount),
      .pos       (live[i]),
      .sprite_idx(4'(i)),
      .hit       (hit[i]),
      .fetch_addr(fetch[i])
    );
  end

  // Lowest index wins; scanning downward lets the last assignment be the winner.
  always_comb begin
    sel_d  = SEL_NONE;
    addr_d = '0;
    if (bright && !busy) begin
      for (int i = N_SPRITES - 1; i >= 0; i--) begin
        if (hit[i]) begin
          sel_d  = SEL_W'(i);
          addr_d = fetch[i];
        end
      end
    end
  end

  // Loader FSM, shadow/live tables and render stage registers. During a load
  // the loader owns ram_addr; otherwise the render path drives it.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state        <= LD_IDLE;
      ld_cnt       <= '0;
      ram_addr     <= '0;
      sel_q        <= SEL_NONE;
      bright_q     <= 1'b0;
      frame_loaded <= 1'b0;
      for (int i = 0; i < N_SPRITES; i++) begin
        shadow[i] <= '0;
        live[i]   <= '0;
      end
    end else if (pix_en) begin
      frame_loaded <= 1'b0;
      ram_addr     <= addr_d;
      sel_q        <= sel_d;
      bright_q     <= bright && !busy;

      if (vblank_start) begin
        // Also abandons any load in flight; its shadow never reaches live.
        state  <= LD_ISSUE;
        ld_cnt <= '0;
      end else begin
        case (state)
          LD_IDLE: ;
          LD_ISSUE: begin
            ram_addr <= ADDR_WIDTH'(POS_BASE);
            ld_cnt   <= CNT_W'(1);
            state    <= LD_CAPTURE;
          end
          LD_CAPTURE: begin
            if (!cap_word[0]) begin
              shadow[cap_word[IDX_W:1]].en <= ram_q[15];
              shadow[cap_word[IDX_W:1]].x  <= ram_q[9:0];
            end else begin
              shadow[cap_word[IDX_W:1]].y  <= ram_q[9:0];
            end
            if (ld_cnt == LAST_CNT) begin
              state <= LD_COMMIT;
            end else begin
              ram_addr <= ADDR_WIDTH'(POS_BASE + 32'(ld_cnt));
              ld_cnt   <= ld_cnt + 1'b1;
            end
          end
          LD_COMMIT: begin
            for (int i = 0; i < N_SPRITES; i++) begin
              live[i] <= shadow[i];
            end
            frame_loaded <= 1'b1;
            state        <= LD_IDLE;
          end
          default: state <= LD_IDLE;
        endcase
      end
    end
  end

  // Colour for the pixel registered on the previous strobe; ram_q now holds its data.
  assign px = decode_pixel(ram_q);

  always_comb begin
    rgb = 24'h0;
    if (bright_q) begin
      rgb = ((sel_q == SEL_NONE) || !px.opaque) ? BG_COLOR : px.rgb;
    end
  end

  assign vga_r = rgb[23:16];
  assign vga_g = rgb[15:8];
  assign vga_b = rgb[7:0];

endmodule

// File: tb/tb_vga_sprite_engine.sv
// tb/tb_vga_sprite_engine.sv - scoreboard bench for vga_sprite_engine
module tb_vga_sprite_engine;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        bright;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_q;
  logic        busy;
  logic        frame_loaded;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;

  logic [15:0] mem [0:65535];

  typedef enum int {K_ADDR, K_RGB, K_BUSY, K_FL, K_WE} kind_t;
  typedef struct {
    int          edge_n;
    kind_t       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   pix_edges    = 0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  localparam logic [31:0] BG = 32'h0088CC88;

  vga_sprite_engine dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .bright      (bright),
    .hcount      (hcount),
    .vcount      (vcount),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_q       (ram_q),
    .busy        (busy),
    .frame_loaded(frame_loaded),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) ram_q <= mem[ram_addr];

  // Expectation for the outputs produced by the next pixel strobe.
  task automatic expect_val(input kind_t k, input logic [31:0] v, input string nm);
    exp_t e;
    e.edge_n = pix_edges + 1;
    e.kind   = k;
    e.val    = v;
    e.name   = nm;
    sb.push_back(e);
  endtask

  // One pixel slot: strobe high for one sys_clk, low for the next.
  task automatic pix(input int h, input int v, input logic b);
    hcount = 10'(h);
    vcount = 10'(v);
    bright = b;
    pix_en = 1'b1;
    @(posedge sys_clk); #1;
    pix_en = 1'b0;
    pix_edges++;
    @(posedge sys_clk); #1;
  endtask

  task automatic chk_px(input int h, input int v, input logic b,
                        input logic [31:0] addr, input logic [31:0] rgb,
                        input string nm);
    expect_val(K_ADDR, addr, {nm, "_addr"});
    expect_val(K_RGB, rgb, {nm, "_rgb"});
    pix(h, v, b);
  endtask

  task automatic expect_idle_zero(input string nm);
    expect_val(K_ADDR, 0, {nm, "_addr"});
    expect_val(K_BUSY, 0, {nm, "_busy"});
    expect_val(K_FL, 0, {nm, "_frame_loaded"});
    expect_val(K_RGB, 0, {nm, "_rgb"});
  endtask

  // vblank strobe plus 11 more slots; a 4-sprite load commits on slot 10.
  task automatic load_table(input bit full_check, input string nm);
    for (int e = 1; e <= 12; e++) begin
      if (full_check) begin
        expect_val(K_BUSY, 32'(e <= 10), {nm, "_busy"});
        expect_val(K_ADDR, (e >= 2 && e <= 9) ? 32'(32'h8000 + e - 2) : 32'h0,
                   {nm, "_addr"});
      end
      if (e >= 10) expect_val(K_FL, 32'(e == 11), {nm, "_frame_loaded"});
      pix((e == 1) ? 0 : e - 1, 480, 1'b0);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < 8; i++) mem[16'(32'h8000 + i)] = 16'h0000;
  endtask

  task automatic set_sprite(input int i, input logic [15:0] w0, input logic [15:0] w1);
    mem[16'(32'h8000 + 2 * i)]     = w0;
    mem[16'(32'h8000 + 2 * i + 1)] = w1;
  endtask

  // Monitor: while a strobe is pending, the outputs hold the previous strobe's result.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (pix_en === 1'b1) begin
        while (sb.size() > 0 && sb[0].edge_n <= pix_edges) begin
          exp_t        e;
          logic [31:0] act;
          e = sb.pop_front();
          case (e.kind)
            K_ADDR:  act = 32'(ram_addr);
            K_RGB:   act = {8'h00, vga_r, vga_g, vga_b};
            K_BUSY:  act = 32'(busy);
            K_WE:    act = 32'(ram_we);
            default: act = 32'(frame_loaded);
          endcase
          tests_run++;
          if (act !== e.val) begin
            tests_failed++;
            $display("FAIL %s (slot %0d): got %h, expected %h", e.name, e.edge_n, act, e.val);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d expectations pending", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    reset  = 1'b1;
    pix_en = 1'b0;
    bright = 1'b0;
    hcount = '0;
    vcount = '0;
    @(posedge sys_clk); #1;

    for (int k = 0; k < 2; k++) begin
      expect_idle_zero("reset");
      expect_val(K_WE, 0, "reset_we");
      pix(0, 0, 1'b0);
    end

    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy_direct: got %b, expected 0", busy);
    end
    tests_run++;
    if (frame_loaded !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_fl_direct: got %b, expected 0", frame_loaded);
    end
    tests_run++;
    if (ram_addr !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_addr_direct: got %h, expected 0000", ram_addr);
    end
    reset = 1'b0;

    // First load: sprite 0 at (100,50), scaled 2x -> 64x64 on screen.
    mem[16'h0000] = 16'hFFFF;
    mem[16'h0021] = 16'h801F;
    set_sprite(0, 16'h8064, 16'h0032);
    load_table(1'b1, "load1");

    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL load1_idle_direct: got %b, expected 0", busy);
    end

    chk_px(100, 50, 1'b1, 32'h0000, 32'h00FFFFFF, "s0_origin");
    chk_px(102, 52, 1'b1, 32'h0021, 32'h000000FF, "s0_2_2");
    chk_px(163, 113, 1'b1, 32'h03FF, BG, "s0_last_px");
    chk_px(164, 50, 1'b1, 32'h0000, BG, "s0_right_miss");
    chk_px(99, 50, 1'b1, 32'h0000, BG, "s0_left_miss");
    chk_px(100, 114, 1'b1, 32'h0000, BG, "s0_below_miss");
    chk_px(102, 52, 1'b0, 32'h0000, 32'h0, "blanking");

    // Priority: sprites 0 and 2 overlap; sprite 0 transparent does not reveal 2.
    clear_table();
    set_sprite(0, 16'h80C8, 16'd100);
    set_sprite(2, 16'h80C8, 16'd100);
    mem[16'h0022] = 16'h0000;
    mem[16'h0023] = 16'hFC00;
    mem[16'h0822] = 16'hFC00;
    load_table(1'b0, "load2");
    chk_px(204, 102, 1'b1, 32'h0022, BG, "prio_transparent");
    chk_px(206, 102, 1'b1, 32'h0023, 32'h00FF0000, "prio_opaque");

    // Reset during load step 3: no commit, live table cleared.
    clear_table();
    set_sprite(0, 16'h8064, 16'h0032);
    for (int k = 0; k < 4; k++) pix(k, 480, 1'b0);
    reset = 1'b1;
    for (int k = 4; k < 6; k++) begin
      expect_idle_zero("mid_load_reset");
      pix(k, 480, 1'b0);
    end
    reset = 1'b0;
    for (int k = 6; k < 16; k++) begin
      expect_val(K_FL, 0, "post_reset_no_commit");
      expect_val(K_BUSY, 0, "post_reset_busy");
      pix(k, 480, 1'b0);
    end
    chk_px(204, 102, 1'b1, 32'h0000, BG, "post_reset_live_clear");
    load_table(1'b0, "load3");
    chk_px(100, 50, 1'b1, 32'h0000, 32'h00FFFFFF, "reload_origin");

    // Table edited mid-frame: old positions stay live until the next commit.
    clear_table();
    set_sprite(0, 16'h812C, 16'd200);
    chk_px(100, 50, 1'b1, 32'h0000, 32'h00FFFFFF, "old_pos_kept");
    chk_px(300, 200, 1'b1, 32'h0000, BG, "new_pos_not_yet");
    load_table(1'b0, "load4");
    chk_px(300, 200, 1'b1, 32'h0000, 32'h00FFFFFF, "new_pos_live");
    chk_px(100, 50, 1'b1, 32'h0000, BG, "old_pos_gone");

    // A second vblank strobe mid-load restarts from word 0.
    for (int k = 0; k < 5; k++) begin
      expect_val(K_FL, 0, "restart_no_commit");
      pix(k, 480, 1'b0);
    end
    load_table(1'b1, "restart");

    // Enable bit clear: never hits.
    clear_table();
    set_sprite(0, 16'h012C, 16'd200);
    load_table(1'b0, "load5");
    chk_px(300, 200, 1'b1, 32'h0000, BG, "dis_origin");
    chk_px(310, 210, 1'b1, 32'h0000, BG, "dis_inside");
    chk_px(363, 263, 1'b1, 32'h0000, BG, "dis_corner");

    pix(0, 0, 1'b0);
    pix(0, 0, 1'b0);

    tests_run++;
    if (ram_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL final_we_direct: got %b, expected 0", ram_we);
    end

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests_run++;
      tests_failed++;
      $display("FAIL %s (slot %0d): never sampled, expected %h", e.name, e.edge_n, e.val);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
